// File: rtl/timer_axi_mc.sv
// Multi-channel down-counter timer behind an AXI4-Lite slave.
// The channels share one prescaler; a single registered irq combines the enabled status bits.
module timer_axi_mc #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 12
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    output logic              irq
);

    localparam int CHW = ADDR_W - 4;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic           ok;
        logic           glb;
        logic [1:0]     off;
        logic [CHW-1:0] ch;
    } dec_t;

    // Word-address decode: block 0 holds the global registers, blocks 16.. the channels.
    function automatic dec_t decode(input logic [ADDR_W-3:0] wa);
        dec_t           d;
        logic [CHW-1:0] blk;
        blk   = wa[ADDR_W-3:2];
        d.off = wa[1:0];
        d.glb = (blk == '0);
        d.ch  = blk - CHW'(16);
        if (d.glb)
            d.ok = (d.off != 2'd3);
        else
            d.ok = (blk >= CHW'(16)) && (d.ch < CHW'(NUM_CH)) && (d.off != 2'd3);
        return d;
    endfunction

    logic              aw_rdy_q, bvalid_q, ar_rdy_q, rvalid_q, irq_q;
    logic [1:0]        bresp_q, rresp_q, rresp_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [15:0]       prescale_q, prescale_d, pre_cnt_q, pre_cnt_d;
    logic [NUM_CH-1:0] irq_sts_q, irq_sts_d, irq_en_q, irq_en_d;
    logic [NUM_CH-1:0] ch_en_q, ch_en_d, ch_rld_q, ch_rld_d;
    logic [CNT_W-1:0]  load_q [NUM_CH];
    logic [CNT_W-1:0]  load_d [NUM_CH];
    logic [CNT_W-1:0]  count_q [NUM_CH];
    logic [CNT_W-1:0]  count_d [NUM_CH];
    logic [NUM_CH-1:0] set_m, clr_m, start_m, wr_ch;

    dec_t wd, rd;
    logic wr_hs, rd_hs, any_en, tick, unused_addr_bits;

    assign wd     = decode(awaddr[ADDR_W-1:2]);
    assign rd     = decode(araddr[ADDR_W-1:2]);
    assign wr_hs  = aw_rdy_q && awvalid && wvalid;
    assign rd_hs  = ar_rdy_q && arvalid;
    assign any_en = |ch_en_q;
    assign tick   = any_en && (pre_cnt_q == prescale_q);
    assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

    always_comb begin
        prescale_d = prescale_q;
        pre_cnt_d  = pre_cnt_q;
        irq_en_d   = irq_en_q;
        ch_en_d    = ch_en_q;
        ch_rld_d   = ch_rld_q;
        load_d     = load_q;
        count_d    = count_q;
        set_m      = '0;
        clr_m      = '0;
        start_m    = '0;
        wr_ch      = '0;

        if (any_en)
            pre_cnt_d = tick ? '0 : pre_cnt_q + 16'd1;

        for (int n = 0; n < NUM_CH; n++) begin
            wr_ch[n]   = wr_hs && wd.ok && !wd.glb && (wd.ch == CHW'(n));
            start_m[n] = wr_ch[n] && (wd.off == 2'd0) && wstrb[0] && wdata[2];
        end

        // START preempts the tick for its channel: no decrement and no event that cycle.
        for (int n = 0; n < NUM_CH; n++) begin
            if (start_m[n]) begin
                count_d[n] = load_q[n];
            end else if (tick && ch_en_q[n]) begin
                if (count_q[n] != '0) begin
                    count_d[n] = count_q[n] - CNT_W'(1);
                end else begin
                    set_m[n] = 1'b1;
                    if (ch_rld_q[n])
                        count_d[n] = load_q[n];
                    else
                        ch_en_d[n] = 1'b0;
                end
            end
            if (wr_ch[n]) begin
                case (wd.off)
                    2'd0: begin
                        if (wstrb[0]) begin
                            ch_en_d[n]  = wdata[0];
                            ch_rld_d[n] = wdata[1];
                        end
                    end
                    2'd1: begin
                        for (int b = 0; b < CNT_W; b++)
                            if (wstrb[b[4:3]]) load_d[n][b] = wdata[b];
                    end
                    default: ;
                endcase
            end
        end

        if (wr_hs && wd.ok && wd.glb) begin
            case (wd.off)
                2'd0: begin
                    for (int b = 0; b < 16; b++)
                        if (wstrb[b[4:3]]) prescale_d[b] = wdata[b];
                    pre_cnt_d = '0;
                end
                2'd1: begin
                    for (int b = 0; b < NUM_CH; b++)
                        clr_m[b] = wstrb[b[4:3]] & wdata[b];
                end
                2'd2: begin
                    for (int b = 0; b < NUM_CH; b++)
                        if (wstrb[b[4:3]]) irq_en_d[b] = wdata[b];
                end
                default: ;
            endcase
        end

        irq_sts_d = (irq_sts_q & ~clr_m) | set_m;
    end

    always_comb begin
        rdata_d = '0;
        rresp_d = rd.ok ? RESP_OKAY : RESP_SLVERR;
        if (rd.ok && rd.glb) begin
            case (rd.off)
                2'd0:    rdata_d = 32'(prescale_q);
                2'd1:    rdata_d = 32'(irq_sts_q);
                2'd2:    rdata_d = 32'(irq_en_q);
                default: rdata_d = '0;
            endcase
        end else if (rd.ok) begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (rd.ch == CHW'(n)) begin
                    case (rd.off)
                        2'd0:    rdata_d = {30'd0, ch_rld_q[n], ch_en_q[n]};
                        2'd1:    rdata_d = 32'(load_q[n]);
                        2'd2:    rdata_d = 32'(count_q[n]);
                        default: rdata_d = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_rdy_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            ar_rdy_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            irq_q      <= 1'b0;
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            irq_sts_q  <= '0;
            irq_en_q   <= '0;
            ch_en_q    <= '0;
            ch_rld_q   <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                load_q[n]  <= '0;
                count_q[n] <= '0;
            end
        end else begin
            aw_rdy_q <= !aw_rdy_q && awvalid && wvalid && !bvalid_q;
            if (wr_hs) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wd.ok ? RESP_OKAY : RESP_SLVERR;
            end else if (bready) begin
                bvalid_q <= 1'b0;
            end
            ar_rdy_q <= !ar_rdy_q && arvalid && !rvalid_q;
            if (rd_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
                rresp_q  <= rresp_d;
            end else if (rready) begin
                rvalid_q <= 1'b0;
            end
            irq_q      <= |(irq_sts_q & irq_en_q);
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
            irq_sts_q  <= irq_sts_d;
            irq_en_q   <= irq_en_d;
            ch_en_q    <= ch_en_d;
            ch_rld_q   <= ch_rld_d;
            load_q     <= load_d;
            count_q    <= count_d;
        end
    end

    assign awready = aw_rdy_q;
    assign wready  = aw_rdy_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = ar_rdy_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_timer_axi_mc.sv
// Directed bench for timer_axi_mc: register map, handshakes, prescaled counting and irq timing.
// Inputs are driven just after the falling edge and outputs sampled on the falling edge.
module tb_timer_axi_mc;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [11:0] awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic mon_on = 1'b0;
    logic irq_drop = 1'b0;

    timer_axi_mc #(.NUM_CH(4), .CNT_W(32), .ADDR_W(12)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .irq(irq)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;
    always @(negedge aclk) if (mon_on && !irq) irq_drop = 1'b1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
        int   n;
        logic ok;
        @(negedge aclk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!awready && n < 20);
        ok = awready;
        if (ok) @(posedge aclk);
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge aclk); n++; end
        ok   = ok && bvalid;
        resp = bresp;
        @(posedge aclk);
        @(negedge aclk);
        bready = 1'b0;
        chk("wr_handshake", 32'(ok), 32'd1);
    endtask

    task automatic axi_rd(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
        int   n;
        logic ok;
        @(negedge aclk);
        araddr = a; arvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!arready && n < 20);
        ok = arready;
        if (ok) @(posedge aclk);
        @(negedge aclk);
        arvalid = 1'b0; rready = 1'b1;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge aclk); n++; end
        ok = ok && rvalid;
        d  = rdata;
        r  = rresp;
        @(posedge aclk);
        @(negedge aclk);
        rready = 1'b0;
        chk("rd_handshake", 32'(ok), 32'd1);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        logic [1:0] r;
        axi_wr(a, d, 4'hF, r);
        chk("wr_resp_okay", 32'(r), 32'd0);
    endtask

    task automatic wr_chk(input string tag, input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] exp_r);
        logic [1:0] r;
        axi_wr(a, d, s, r);
        chk(tag, 32'(r), 32'(exp_r));
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp_d,
                          input logic [1:0] exp_r);
        logic [31:0] d;
        logic [1:0]  r;
        axi_rd(a, d, r);
        chk({tag, "_data"}, d, exp_d);
        chk({tag, "_resp"}, 32'(r), 32'(exp_r));
    endtask

    task automatic wait_irq(input string tag, output int at_cyc);
        int n;
        n = 0;
        while (!irq && n < 60) begin @(negedge aclk); n++; end
        chk(tag, 32'(irq), 32'd1);
        at_cyc = cyc;
    endtask

    initial begin
        logic [11:0] rst_addr [7];
        int          base, c1, c2;

        rst_addr = '{12'h000, 12'h004, 12'h008, 12'h100, 12'h104, 12'h108, 12'h118};
        aresetn = 1'b0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge aclk);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        aresetn = 1'b1;

        // Reset contents and decode errors
        foreach (rst_addr[i]) rd_chk("rst_reg", rst_addr[i], 32'd0, 2'b00);
        rd_chk("rsvd_10c", 12'h10C, 32'd0, 2'b10);
        rd_chk("rsvd_00c", 12'h00C, 32'd0, 2'b10);
        rd_chk("gap_0f0", 12'h0F0, 32'd0, 2'b10);
        rd_chk("ch_oor", 12'h140, 32'd0, 2'b10);
        wr_chk("wr_rsvd", 12'h00C, 32'h1, 4'hF, 2'b10);
        wr_chk("wr_gap", 12'h050, 32'h1, 4'hF, 2'b10);
        wr_chk("wr_ch_oor", 12'h144, 32'h1, 4'hF, 2'b10);
        wr_chk("wr_count", 12'h108, 32'h7, 4'hF, 2'b00);
        rd_chk("count_ro", 12'h108, 32'd0, 2'b00);

        // ch0 one-shot, PRESCALE=0: count 3->0 on E1..E3, event E4, irq E5
        wr(12'h000, 32'd0);
        wr(12'h008, 32'h1);
        wr(12'h104, 32'd3);
        wr(12'h100, 32'h5);
        repeat (3) @(negedge aclk);
        chk("irq_not_yet", 32'(irq), 32'd0);
        @(negedge aclk);
        chk("irq_oneshot", 32'(irq), 32'd1);
        rd_chk("sts_ch0", 12'h004, 32'h1, 2'b00);
        rd_chk("ctrl_ch0_en_clr", 12'h100, 32'h0, 2'b00);
        rd_chk("count_ch0_end", 12'h108, 32'h0, 2'b00);
        wr(12'h004, 32'h1);
        chk("irq_after_w1c", 32'(irq), 32'd0);

        // ch3 one-shot, PRESCALE=31: ticks every 32 cycles, sampled once per period
        wr(12'h000, 32'd31);
        wr(12'h134, 32'd3);
        wr(12'h130, 32'h5);
        base = cyc;
        for (int k = 0; k < 4; k++) begin
            while (cyc < base + 32 * k) @(negedge aclk);
            rd_chk("count_seq", 12'h138, 32'(3 - k), 2'b00);
        end
        while (cyc < base + 140) @(negedge aclk);
        rd_chk("sts_ch3", 12'h004, 32'h8, 2'b00);
        rd_chk("ctrl_ch3_en_clr", 12'h130, 32'h0, 2'b00);
        wr(12'h004, 32'h8);

        // ch1 auto-reload, PRESCALE=2, LOAD=1: event every 6 cycles
        wr(12'h000, 32'd2);
        wr(12'h008, 32'h2);
        wr(12'h114, 32'd1);
        wr(12'h110, 32'h7);
        wait_irq("irq_ch1_first", c1);
        wr(12'h004, 32'h2);
        chk("irq_ch1_cleared", 32'(irq), 32'd0);
        wait_irq("irq_ch1_second", c2);
        chk("reload_period", 32'(c2 - c1), 32'd6);
        rd_chk("count_alt0", 12'h118, 32'd0, 2'b00);
        rd_chk("count_alt1", 12'h118, 32'd1, 2'b00);
        rd_chk("ctrl_ch1_en_kept", 12'h110, 32'h3, 2'b00);

        // Byte strobes on LOAD
        wr(12'h124, 32'hAABB_CCDD);
        wr_chk("wr_strb", 12'h124, 32'h1122_3344, 4'b0101, 2'b00);
        rd_chk("load_strb", 12'h124, 32'hAA22_CC44, 2'b00);

        // Handshake rules: neither valid alone is accepted; bvalid holds and blocks a new write
        @(negedge aclk);
        awaddr = 12'h134; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("aw_alone", 32'(awready), 32'd0);
        end
        awvalid = 1'b0; wvalid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            chk("w_alone", 32'(wready), 32'd0);
        end
        awvalid = 1'b1;
        @(negedge aclk);
        chk("aw_rdy", 32'(awready), 32'd1);
        chk("w_rdy", 32'(wready), 32'd1);
        @(posedge aclk);
        @(negedge aclk);
        wdata = 32'h66;
        for (int i = 0; i < 4; i++) begin
            chk("bvalid_hold", 32'(bvalid), 32'd1);
            chk("bresp_hold", 32'(bresp), 32'd0);
            chk("no_2nd_accept", 32'(awready), 32'd0);
            @(negedge aclk);
        end
        bready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bready = 1'b0;
        chk("bvalid_drop", 32'(bvalid), 32'd0);
        begin
            int n;
            n = 0;
            while (!awready && n < 10) begin @(negedge aclk); n++; end
            chk("aw_2nd", 32'(awready), 32'd1);
        end
        @(posedge aclk);
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bready = 1'b0;
        rd_chk("load_2nd", 12'h134, 32'h66, 2'b00);

        // Set wins over a coincident W1C: ch0 reload with LOAD=0 fires every cycle
        wr(12'h110, 32'h0);
        wr(12'h004, 32'h2);
        wr(12'h000, 32'd0);
        wr(12'h008, 32'h1);
        wr(12'h104, 32'd0);
        wr(12'h100, 32'h7);
        @(negedge aclk);
        chk("irq_every_tick", 32'(irq), 32'd1);
        mon_on = 1'b1;
        wr(12'h004, 32'h1);
        rd_chk("sts_set_wins", 12'h004, 32'h1, 2'b00);
        mon_on = 1'b0;
        chk("irq_no_drop", 32'(irq_drop), 32'd0);

        // Reset with bvalid pending
        @(negedge aclk);
        awaddr = 12'h008; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge aclk);
        @(posedge aclk);
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bvalid_pre_rst", 32'(bvalid), 32'd1);
        aresetn = 1'b0;
        #1;
        chk("bvalid_async_rst", 32'(bvalid), 32'd0);
        chk("irq_async_rst", 32'(irq), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        rd_chk("ctrl_after_rst", 12'h100, 32'h0, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
